btn_conditioner: RTL and testbench

//   Input-conditioning stage that sits directly upstream of the floor-sequencing controller.

---
 rtl/btn_conditioner.sv | 67 ++++++
 tb/tb_btn_conditioner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Per-channel button conditioner: two-flop synchroniser, debounce counter,
// clean registered level and a one-cycle press pulse on each debounced rising edge.
module btn_conditioner #(
    parameter int NUM_BTN = 5,
    parameter int DEB_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press
);
    localparam int               CNT_W   = $clog2(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] press_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];

    // A channel's count only survives while its synchronised input disagrees with
    // the accepted level; the level flips on the DEB_CYC-th consecutive disagreement.
    always_comb begin
        level_d = level_q;
        press_d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus randomised bouncing inputs,
// compared each cycle against a sliding-window model of the debounce rule.
module tb_btn_conditioner;
    localparam int NUM_BTN = 5;
    localparam int DEB_CYC = 4;

    typedef logic [NUM_BTN-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vec_t btn_raw = '0;
    vec_t btn_level;
    vec_t btn_press;

    int errors = 0;
    int checks = 0;

    btn_conditioner #(.NUM_BTN(NUM_BTN), .DEB_CYC(DEB_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_press (btn_press)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: raw samples taken at every edge. The level flips at an edge when the
    // raw values sampled 2..DEB_CYC+1 edges earlier all disagree with the current level.
    vec_t hist[$];
    vec_t m_level;
    vec_t m_press;

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < DEB_CYC + 2; k++) hist.push_back('0);
        m_level = '0;
        m_press = '0;
    endfunction

    function automatic void model_edge(input vec_t raw);
        vec_t nl;
        vec_t np;
        int   sz;
        nl = m_level;
        np = '0;
        hist.push_back(raw);
        sz = hist.size();
        for (int ch = 0; ch < NUM_BTN; ch++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int j = 0; j < DEB_CYC; j++) begin
                if (hist[sz - 3 - j][ch] == m_level[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
                nl[ch] = ~m_level[ch];
                np[ch] = ~m_level[ch];
            end
        end
        m_level = nl;
        m_press = np;
        while (hist.size() > DEB_CYC + 2) void'(hist.pop_front());
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic step(input vec_t raw);
        btn_raw = raw;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(raw);
        @(negedge clk);
        check("level", 32'(btn_level), 32'(m_level));
        check("press", 32'(btn_press), 32'(m_press));
    endtask

    // Called at a negedge: asynchronous mid-cycle assertion with all inputs high.
    task automatic apply_reset();
        btn_raw = '1;
        #2 rst = 1'b1;
        #1;
        check("rst_level_async", 32'(btn_level), 32'd0);
        check("rst_press_async", 32'(btn_press), 32'd0);
        model_reset();
        step('1);
        step('1);
        rst     = 1'b0;
        btn_raw = '0;
    endtask

    initial begin
        vec_t seen;
        vec_t r;
        int   rise_edge;
        int   pulses;
        int   flip_div;
        int   bounce [6] = '{1, 0, 1, 1, 0, 1};

        model_reset();
        #1;
        check("rst_level_init", 32'(btn_level), 32'd0);
        check("rst_press_init", 32'(btn_press), 32'd0);
        @(negedge clk);
        step('1);
        step('1);
        check("rst_level_held", 32'(btn_level), 32'd0);
        rst     = 1'b0;
        btn_raw = '0;

        // Clean press on channel 2
        for (int e = 1; e <= 8; e++) begin
            step(5'b00100);
            if (e == 5) check("t2_level_edge5", 32'(btn_level), 32'd0);
            if (e == 6) begin
                check("t2_level_edge6", 32'(btn_level), 32'b00100);
                check("t2_press_edge6", 32'(btn_press), 32'b00100);
            end
            if (e == 7) check("t2_press_edge7", 32'(btn_press), 32'd0);
        end

        // Glitch on channel 0 shorter than the debounce window
        apply_reset();
        seen = '0;
        for (int e = 1; e <= 13; e++) begin
            step((e <= 3) ? vec_t'(5'b00001) : vec_t'(5'b00000));
            seen |= btn_level | btn_press;
        end
        check("t3_glitch", 32'(seen), 32'd0);

        // Bounce on channel 3, then held
        apply_reset();
        pulses    = 0;
        rise_edge = -1;
        for (int e = 1; e <= 18; e++) begin
            r = (e <= 6) ? vec_t'(bounce[e-1] << 3) : vec_t'(5'b01000);
            step(r);
            if (btn_press[3]) pulses++;
            if (btn_level[3] && rise_edge < 0) rise_edge = e;
        end
        check("t4_pulses", 32'(pulses), 32'd1);
        check("t4_rise_edge", 32'(rise_edge), 32'd11);

        // Release on channel 1
        apply_reset();
        for (int e = 1; e <= 8; e++) step(5'b00010);
        check("t5_level_on", 32'(btn_level), 32'b00010);
        seen      = '0;
        rise_edge = -1;
        for (int e = 1; e <= 10; e++) begin
            step(5'b00000);
            seen |= btn_press;
            if (!btn_level[1] && rise_edge < 0) rise_edge = e;
        end
        check("t5_fall_edge", 32'(rise_edge), 32'd6);
        check("t5_no_press", 32'(seen), 32'd0);

        // Parallel channels, reset pulsed mid-count with inputs held
        apply_reset();
        seen = '0;
        for (int e = 1; e <= 3; e++) begin
            step(5'b10101);
            seen |= btn_level | btn_press;
        end
        check("t6_pre_reset", 32'(seen), 32'd0);
        #1 rst = 1'b1;
        model_reset();
        step(5'b10101);
        rst       = 1'b0;
        rise_edge = -1;
        pulses    = 0;
        for (int e = 1; e <= 10; e++) begin
            step(5'b10101);
            if (btn_level == 5'b10101 && rise_edge < 0) begin
                rise_edge = e;
                check("t6_press", 32'(btn_press), 32'b10101);
            end
            if (btn_press != '0) pulses++;
        end
        check("t6_rise_edge", 32'(rise_edge), 32'd6);
        check("t6_pulse_cycles", 32'(pulses), 32'd1);

        // Randomised bouncing inputs with varying flip rates and occasional resets
        r        = '0;
        flip_div = 2;
        for (int c = 0; c < 1200; c++) begin
            if (c % 60 == 0) flip_div = int'($urandom_range(1, 12));
            for (int ch = 0; ch < NUM_BTN; ch++) begin
                if ($urandom_range(flip_div) == 0) r[ch] = ~r[ch];
            end
            if ($urandom_range(249) == 0) begin
                #1 rst = 1'b1;
                #1;
                check("rand_rst_level", 32'(btn_level), 32'd0);
                check("rand_rst_press", 32'(btn_press), 32'd0);
                model_reset();
                step(r);
                rst = 1'b0;
            end else begin
                step(r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
